occupancy_gate_ctrl: RTL and testbench



---
 rtl/occupancy_gate_ctrl.sv | 170 +++++++++++++++++
 tb/tb_occupancy_gate_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/occupancy_gate_ctrl.sv
// Parking-lot occupancy counter with saturating count, sticky error flags,
// and an entry-barrier FSM (CLOSED / OPEN / DENY) driven by the current full status.
module occupancy_gate_ctrl #(
    parameter int BITS           = 8,
    parameter int CAPACITY       = 99,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            enter,
    input  logic            exit,
    input  logic            arrive,
    input  logic            load,
    input  logic [BITS-1:0] load_value,
    input  logic            err_clr,
    output logic [BITS-1:0] count,
    output logic            full,
    output logic            empty,
    output logic            overflow_err,
    output logic            underflow_err,
    output logic            gate_open,
    output logic            deny
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [BITS-1:0] CAP_V  = BITS'(CAPACITY);
    localparam logic [BITS-1:0] ZERO_V = {BITS{1'b0}};
    localparam logic [BITS-1:0] ONE_V  = BITS'(1);
    localparam logic [TW-1:0]   T_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0]   T_ONE  = TW'(1);
    localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_CLOSED = 2'd0;
    localparam logic [1:0] ST_OPEN   = 2'd1;
    localparam logic [1:0] ST_DENY   = 2'd2;

    logic [BITS-1:0] count_r, count_next_s;
    logic            ovf_r, ovf_next_s;
    logic            unf_r, unf_next_s;
    logic [1:0]      state_r, state_next_s;
    logic [TW-1:0]   timer_r, timer_next_s;
    logic            gate_open_r, deny_r;
    logic            full_s, empty_s;
    logic            ovf_event_s, unf_event_s;

    // Status decode from the count register only.
    always_comb begin
        full_s  = (count_r == CAP_V);
        empty_s = (count_r == ZERO_V);
    end

    // Next count and error-event detection, load first then enter/exit.
    always_comb begin
        count_next_s = count_r;
        ovf_event_s  = 1'b0;
        unf_event_s  = 1'b0;
        if (load) begin
            count_next_s = (load_value > CAP_V) ? CAP_V : load_value;
        end else if (enter && exit) begin
            count_next_s = count_r;
        end else if (enter) begin
            if (count_r < CAP_V) begin
                count_next_s = count_r + ONE_V;
            end else begin
                ovf_event_s = 1'b1;
            end
        end else if (exit) begin
            if (count_r > ZERO_V) begin
                count_next_s = count_r - ONE_V;
            end else begin
                unf_event_s = 1'b1;
            end
        end else begin
            count_next_s = count_r;
        end
    end

    // Sticky error flags: a fresh error outranks err_clr in the same cycle.
    always_comb begin
        if (load) begin
            ovf_next_s = 1'b0;
            unf_next_s = 1'b0;
        end else begin
            if (ovf_event_s) begin
                ovf_next_s = 1'b1;
            end else if (err_clr) begin
                ovf_next_s = 1'b0;
            end else begin
                ovf_next_s = ovf_r;
            end
            if (unf_event_s) begin
                unf_next_s = 1'b1;
            end else if (err_clr) begin
                unf_next_s = 1'b0;
            end else begin
                unf_next_s = unf_r;
            end
        end
    end

    // Barrier FSM next state; the timer only runs while OPEN.
    always_comb begin
        state_next_s = state_r;
        timer_next_s = T_ZERO;
        case (state_r)
            ST_CLOSED: begin
                if (arrive && !full_s) begin
                    state_next_s = ST_OPEN;
                end else if (arrive && full_s) begin
                    state_next_s = ST_DENY;
                end else begin
                    state_next_s = ST_CLOSED;
                end
            end
            ST_OPEN: begin
                if (enter) begin
                    state_next_s = ST_CLOSED;
                end else if (timer_r == T_LAST) begin
                    state_next_s = ST_CLOSED;
                end else begin
                    state_next_s = ST_OPEN;
                    timer_next_s = timer_r + T_ONE;
                end
            end
            ST_DENY: begin
                if (!arrive) begin
                    state_next_s = ST_CLOSED;
                end else if (!full_s) begin
                    state_next_s = ST_OPEN;
                end else begin
                    state_next_s = ST_DENY;
                end
            end
            default: begin
                state_next_s = ST_CLOSED;
            end
        endcase
    end

    // State, count, flags and registered Moore outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r     <= ZERO_V;
            ovf_r       <= 1'b0;
            unf_r       <= 1'b0;
            state_r     <= ST_CLOSED;
            timer_r     <= T_ZERO;
            gate_open_r <= 1'b0;
            deny_r      <= 1'b0;
        end else begin
            count_r     <= count_next_s;
            ovf_r       <= ovf_next_s;
            unf_r       <= unf_next_s;
            state_r     <= state_next_s;
            timer_r     <= timer_next_s;
            gate_open_r <= (state_next_s == ST_OPEN);
            deny_r      <= (state_next_s == ST_DENY);
        end
    end

    assign count         = count_r;
    assign full          = full_s;
    assign empty         = empty_s;
    assign overflow_err  = ovf_r;
    assign underflow_err = unf_r;
    assign gate_open     = gate_open_r;
    assign deny          = deny_r;

endmodule

// File: tb/tb_occupancy_gate_ctrl.sv
// Directed bench for occupancy_gate_ctrl: counter vectors from a table,
// then hand-written barrier sequences (admit, timeout, deny, async reset).
module tb_occupancy_gate_ctrl;

    localparam int BITS = 8;
    localparam int CAP  = 5;
    localparam int TMO  = 8;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            enter, exit, arrive, load, err_clr;
    logic [BITS-1:0] load_value;
    logic [BITS-1:0] count;
    logic            full, empty, overflow_err, underflow_err, gate_open, deny;

    int n_total = 0;
    int n_pass  = 0;

    occupancy_gate_ctrl #(.BITS(BITS), .CAPACITY(CAP), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .enter(enter), .exit(exit), .arrive(arrive),
        .load(load), .load_value(load_value), .err_clr(err_clr), .count(count),
        .full(full), .empty(empty), .overflow_err(overflow_err),
        .underflow_err(underflow_err), .gate_open(gate_open), .deny(deny)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en, ex, ld, ec;
        logic [7:0] lv;
        int         c;
        logic       f, e, o, u;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic en, input logic ex, input logic ld,
                                input logic [7:0] lv, input logic ec, input int c,
                                input logic f, input logic e, input logic o, input logic u);
        vec_t v;
        v.en = en; v.ex = ex; v.ld = ld; v.lv = lv; v.ec = ec;
        v.c = c; v.f = f; v.e = e; v.o = o; v.u = u;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input int act, input int exp_v);
        n_total++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pulses();
        enter = 1'b0; exit = 1'b0; load = 1'b0; err_clr = 1'b0; load_value = 8'd0;
    endtask

    initial begin
        int n_high;
        reset_n = 1'b0; arrive = 1'b0;
        clear_pulses();
        repeat (3) step();
        reset_n = 1'b1;
        step();
        chk("rst count", int'(count), 0);
        chk("rst empty", int'(empty), 1);
        chk("rst full", int'(full), 0);
        chk("rst gate_open", int'(gate_open), 0);
        chk("rst deny", int'(deny), 0);
        chk("rst ovf", int'(overflow_err), 0);
        chk("rst unf", int'(underflow_err), 0);

        //   en    ex    ld    lv      ec     cnt f     e     o     u
        add(1'b1, 1'b0, 1'b0, 8'd0,   1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 8'd0,   1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 8'd0,   1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 8'd0,   1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 8'd0,   1'b0, 4, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 8'd0,   1'b0, 5, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 8'd0,   1'b0, 5, 1'b1, 1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 8'd0,   1'b1, 5, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 8'd0,   1'b1, 5, 1'b1, 1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 8'd0,   1'b1, 5, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 8'd0,   1'b0, 4, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 8'd0,   1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 8'd0,   1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
        add(1'b0, 1'b1, 1'b0, 8'd0,   1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b0, 8'd0,   1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 8'd0,   1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
        add(1'b1, 1'b0, 1'b0, 8'd0,   1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b0, 1'b0, 8'd0,   1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b1, 1'b0, 8'd0,   1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b1, 8'd200, 1'b0, 5, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 8'd0,   1'b0, 5, 1'b1, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b1, 8'd0,   1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 8'd3,   1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 8'd5,   1'b0, 5, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 8'd0,   1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            enter = vecs[i].en; exit = vecs[i].ex; load = vecs[i].ld;
            load_value = vecs[i].lv; err_clr = vecs[i].ec;
            step();
            chk($sformatf("v%0d count", i), int'(count), vecs[i].c);
            chk($sformatf("v%0d full", i), int'(full), int'(vecs[i].f));
            chk($sformatf("v%0d empty", i), int'(empty), int'(vecs[i].e));
            chk($sformatf("v%0d ovf", i), int'(overflow_err), int'(vecs[i].o));
            chk($sformatf("v%0d unf", i), int'(underflow_err), int'(vecs[i].u));
            chk($sformatf("v%0d gate", i), int'(gate_open), 0);
        end
        clear_pulses();

        // Admit: open one cycle after arrive, close one cycle after enter.
        arrive = 1'b1;
        step();
        chk("admit open", int'(gate_open), 1);
        chk("admit deny", int'(deny), 0);
        step();
        step();
        chk("admit still open", int'(gate_open), 1);
        enter = 1'b1; arrive = 1'b0;
        step();
        enter = 1'b0;
        chk("admit closed", int'(gate_open), 0);
        chk("admit count", int'(count), 1);
        step();
        chk("admit stays closed", int'(gate_open), 0);

        // Timeout: exactly TMO open cycles, one closed cycle, then reopen.
        arrive = 1'b1;
        step();
        n_high = gate_open ? 1 : 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (gate_open) n_high++;
            else break;
        end
        chk("timeout open cycles", n_high, TMO);
        chk("timeout closed", int'(gate_open), 0);
        step();
        chk("timeout reopen", int'(gate_open), 1);
        enter = 1'b1;
        step();
        enter = 1'b0;
        chk("timeout enter close", int'(gate_open), 0);
        chk("timeout count", int'(count), 2);

        // Deny, then an exit frees a space and the gate opens.
        arrive = 1'b0;
        load = 1'b1; load_value = 8'd5;
        step();
        clear_pulses();
        chk("deny full", int'(full), 1);
        arrive = 1'b1;
        step();
        chk("deny set", int'(deny), 1);
        chk("deny gate", int'(gate_open), 0);
        step();
        chk("deny hold", int'(deny), 1);
        exit = 1'b1;
        step();
        exit = 1'b0;
        chk("deny exit count", int'(count), 4);
        chk("deny exit full", int'(full), 0);
        chk("deny exit still deny", int'(deny), 1);
        step();
        chk("release deny", int'(deny), 0);
        chk("release open", int'(gate_open), 1);
        enter = 1'b1;
        step();
        enter = 1'b0;
        chk("refill closed", int'(gate_open), 0);
        chk("refill full", int'(full), 1);
        step();
        chk("redeny", int'(deny), 1);
        arrive = 1'b0;
        step();
        chk("drop deny", int'(deny), 0);
        chk("drop gate", int'(gate_open), 0);

        // Async reset aborts DENY immediately.
        arrive = 1'b1;
        step();
        chk("pre-reset deny", int'(deny), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async rst deny", int'(deny), 0);
        chk("async rst count", int'(count), 0);
        chk("async rst empty", int'(empty), 1);
        arrive = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        chk("post rst gate", int'(gate_open), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
